// File: rtl/ex_operand_stage_if.sv
// ID/EX operand-stage bus: decoded ID-stage inputs, the EX/MEM and MEM/WB forwarding
// sources, and the latched EX-stage outputs that feed the ALU.
interface ex_operand_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4
);
    logic                  stall;
    logic                  flush;
    logic                  id_valid;
    logic [DATA_W-1:0]     id_read_data_1;
    logic [DATA_W-1:0]     id_read_data_2;
    logic [DATA_W-1:0]     id_imm_ext;
    logic [4:0]            id_shamt;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [ALU_CTRL_W-1:0] id_alu_control;
    logic                  id_alu_src;
    logic                  id_shift_src;
    logic                  id_reg_dst;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_write_reg;
    logic [DATA_W-1:0]     mem_alu_result;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_write_reg;
    logic [DATA_W-1:0]     wb_write_data;
    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [DATA_W-1:0]     ex_store_data;
    logic [REG_ADDR_W-1:0] ex_write_reg;
    logic                  ex_valid;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  load_use_hazard;

    // Pipeline side: drives the ID inputs and forwarding sources.
    modport master (
        output stall, flush, id_valid, id_read_data_1, id_read_data_2, id_imm_ext,
               id_shamt, id_rs, id_rt, id_rd, id_alu_control, id_alu_src, id_shift_src,
               id_reg_dst, id_reg_write, id_mem_read, id_mem_write,
               mem_reg_write, mem_write_reg, mem_alu_result,
               wb_reg_write, wb_write_reg, wb_write_data,
        input  alu_a, alu_b, alu_control, ex_store_data, ex_write_reg,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard
    );

    // Operand stage side.
    modport slave (
        input  stall, flush, id_valid, id_read_data_1, id_read_data_2, id_imm_ext,
               id_shamt, id_rs, id_rt, id_rd, id_alu_control, id_alu_src, id_shift_src,
               id_reg_dst, id_reg_write, id_mem_read, id_mem_write,
               mem_reg_write, mem_write_reg, mem_alu_result,
               wb_reg_write, wb_write_reg, wb_write_data,
        output alu_a, alu_b, alu_control, ex_store_data, ex_write_reg,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and selection for the EX-stage ALU,
// plus the load-use hazard flag consumed by the hazard unit.
module ex_operand_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4
) (
    input logic               clk,
    input logic               reset,
    ex_operand_stage_if.slave bus
);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0010);

    logic                  ex_valid_q;
    logic                  ex_reg_write_q;
    logic                  ex_mem_read_q;
    logic                  ex_mem_write_q;
    logic [DATA_W-1:0]     ex_rd1_q;
    logic [DATA_W-1:0]     ex_rd2_q;
    logic [DATA_W-1:0]     ex_imm_q;
    logic [4:0]            ex_shamt_q;
    logic [REG_ADDR_W-1:0] ex_rs_q;
    logic [REG_ADDR_W-1:0] ex_rt_q;
    logic [REG_ADDR_W-1:0] ex_write_reg_q;
    logic [ALU_CTRL_W-1:0] ex_alu_control_q;
    logic                  ex_alu_src_q;
    logic                  ex_shift_src_q;

    logic [DATA_W-1:0]     fwd_rs;
    logic [DATA_W-1:0]     fwd_rt;

    // ID/EX register: flush inserts a bubble, stall holds, otherwise latch the ID slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || bus.flush) begin
            ex_valid_q       <= 1'b0;
            ex_reg_write_q   <= 1'b0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_rd1_q         <= '0;
            ex_rd2_q         <= '0;
            ex_imm_q         <= '0;
            ex_shamt_q       <= '0;
            ex_rs_q          <= '0;
            ex_rt_q          <= '0;
            ex_write_reg_q   <= '0;
            ex_alu_control_q <= ALU_ADD;
            ex_alu_src_q     <= 1'b0;
            ex_shift_src_q   <= 1'b0;
        end else if (!bus.stall) begin
            ex_valid_q       <= bus.id_valid;
            ex_reg_write_q   <= bus.id_valid & bus.id_reg_write;
            ex_mem_read_q    <= bus.id_valid & bus.id_mem_read;
            ex_mem_write_q   <= bus.id_valid & bus.id_mem_write;
            ex_rd1_q         <= bus.id_read_data_1;
            ex_rd2_q         <= bus.id_read_data_2;
            ex_imm_q         <= bus.id_imm_ext;
            ex_shamt_q       <= bus.id_shamt;
            ex_rs_q          <= bus.id_rs;
            ex_rt_q          <= bus.id_rt;
            ex_write_reg_q   <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            ex_alu_control_q <= bus.id_alu_control;
            ex_alu_src_q     <= bus.id_alu_src;
            ex_shift_src_q   <= bus.id_shift_src;
        end
    end

    // Forwarding: EX/MEM beats MEM/WB, register 0 is never forwarded.
    always_comb begin
        fwd_rs = ex_rd1_q;
        fwd_rt = ex_rd2_q;
        if (bus.mem_reg_write && bus.mem_write_reg != '0 && bus.mem_write_reg == ex_rs_q)
            fwd_rs = bus.mem_alu_result;
        else if (bus.wb_reg_write && bus.wb_write_reg != '0 && bus.wb_write_reg == ex_rs_q)
            fwd_rs = bus.wb_write_data;
        if (bus.mem_reg_write && bus.mem_write_reg != '0 && bus.mem_write_reg == ex_rt_q)
            fwd_rt = bus.mem_alu_result;
        else if (bus.wb_reg_write && bus.wb_write_reg != '0 && bus.wb_write_reg == ex_rt_q)
            fwd_rt = bus.wb_write_data;
    end

    // Operand select: shift form shifts rt by shamt, otherwise rs op (imm | rt).
    always_comb begin
        if (ex_shift_src_q) begin
            bus.alu_a = fwd_rt;
            bus.alu_b = {{(DATA_W-5){1'b0}}, ex_shamt_q};
        end else begin
            bus.alu_a = fwd_rs;
            bus.alu_b = ex_alu_src_q ? ex_imm_q : fwd_rt;
        end
    end

    assign bus.ex_store_data = fwd_rt;
    assign bus.alu_control   = ex_alu_control_q;
    assign bus.ex_write_reg  = ex_write_reg_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_reg_write  = ex_reg_write_q;
    assign bus.ex_mem_read   = ex_mem_read_q;
    assign bus.ex_mem_write  = ex_mem_write_q;

    // Conservative load-use check: rt is compared for every instruction in ID.
    assign bus.load_use_hazard = ex_valid_q & ex_mem_read_q & (ex_write_reg_q != '0) &
                                 ((ex_write_reg_q == bus.id_rs) | (ex_write_reg_q == bus.id_rt));
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: stimulus pushes hand-computed expectations into a
// queue; a negedge monitor pops and compares against the DUT outputs.
module tb_ex_operand_stage;
  logic clk;
  logic reset;

  ex_operand_stage_if #(.DATA_W(32), .REG_ADDR_W(5), .ALU_CTRL_W(4)) bus ();

  ex_operand_stage #(.DATA_W(32), .REG_ADDR_W(5), .ALU_CTRL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic        v;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        hz;
  } outs_t;

  typedef struct {
    string name;
    outs_t val;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t  e;
      outs_t act;
      e   = q.pop_front();
      act = {bus.alu_a, bus.alu_b, bus.alu_control, bus.ex_store_data, bus.ex_write_reg,
             bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
             bus.load_use_hazard};
      total++;
      if (act !== e.val)
        $display("FAIL %s: got a=%h b=%h ctrl=%h sd=%h wr=%0d v/rw/mr/mw/hz=%b%b%b%b%b, want a=%h b=%h ctrl=%h sd=%h wr=%0d v/rw/mr/mw/hz=%b%b%b%b%b",
                 e.name, act.a, act.b, act.ctrl, act.sd, act.wr, act.v, act.rw, act.mr, act.mw, act.hz,
                 e.val.a, e.val.b, e.val.ctrl, e.val.sd, e.val.wr, e.val.v, e.val.rw, e.val.mr, e.val.mw, e.val.hz);
      else
        passed++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

  task automatic expect_out(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] ctrl, input logic [31:0] sd, input logic [4:0] wr,
                            input logic v, input logic rw, input logic mr, input logic mw,
                            input logic hz);
    exp_t e;
    e.name = name;
    e.val  = {a, b, ctrl, sd, wr, v, rw, mr, mw, hz};
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [4:0] sh, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [3:0] ctrl,
                        input logic asrc, input logic ssrc, input logic rdst,
                        input logic rw, input logic mr, input logic mw);
    bus.id_valid = v;       bus.id_read_data_1 = rd1; bus.id_read_data_2 = rd2;
    bus.id_imm_ext = imm;   bus.id_shamt = sh;        bus.id_rs = rs;
    bus.id_rt = rt;         bus.id_rd = rd;           bus.id_alu_control = ctrl;
    bus.id_alu_src = asrc;  bus.id_shift_src = ssrc;  bus.id_reg_dst = rdst;
    bus.id_reg_write = rw;  bus.id_mem_read = mr;     bus.id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic mrw, input logic [4:0] mreg, input logic [31:0] mres,
                         input logic wrw, input logic [4:0] wreg, input logic [31:0] wdat);
    bus.mem_reg_write = mrw; bus.mem_write_reg = mreg; bus.mem_alu_result = mres;
    bus.wb_reg_write  = wrw; bus.wb_write_reg  = wreg; bus.wb_write_data  = wdat;
  endtask

  task automatic load_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (bus.alu_control !== 4'h2 || bus.ex_valid !== 1'b0 || bus.alu_a !== 32'h0)
      $display("FAIL reset_direct: got ctrl=%h v=%b a=%h, want ctrl=2 v=0 a=0",
               bus.alu_control, bus.ex_valid, bus.alu_a);
    else
      passed++;
    expect_out("reset_state", 0, 0, 4'h2, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // rs=5 forwarding priority
    set_id(1, 32'h11, 32'h22, 32'h100, 0, 5, 6, 9, 4'h2, 0, 0, 1, 1, 0, 0);
    load_edge();
    set_fwd(1, 5, 32'hAA, 1, 5, 32'h55);
    #1;
    total++;
    if (bus.alu_a !== 32'hAA)
      $display("FAIL fwd_mem_direct: got a=%h, want a=000000aa", bus.alu_a);
    else
      passed++;
    expect_out("fwd_mem_prio", 32'hAA, 32'h22, 4'h2, 32'h22, 9, 1, 1, 0, 0, 0);
    set_fwd(0, 5, 32'hAA, 1, 5, 32'h55);
    expect_out("fwd_wb", 32'h55, 32'h22, 4'h2, 32'h22, 9, 1, 1, 0, 0, 0);
    set_fwd(0, 5, 32'hAA, 0, 5, 32'h55);
    expect_out("fwd_none", 32'h11, 32'h22, 4'h2, 32'h22, 9, 1, 1, 0, 0, 0);
    set_fwd(1, 6, 32'hAA, 0, 0, 0);
    expect_out("fwd_rt_mem", 32'h11, 32'hAA, 4'h2, 32'hAA, 9, 1, 1, 0, 0, 0);

    // register 0 never forwarded; immediate select; dest = rt
    set_id(1, 0, 32'h33, 32'h44, 0, 0, 2, 0, 4'h6, 1, 0, 0, 1, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    load_edge();
    set_fwd(1, 0, 32'hFFFF, 1, 0, 32'h77);
    #1;
    total++;
    if (bus.alu_a !== 32'h0)
      $display("FAIL r0_direct: got a=%h, want a=00000000", bus.alu_a);
    else
      passed++;
    expect_out("r0_no_fwd", 0, 32'h44, 4'h6, 32'h33, 2, 1, 1, 0, 0, 0);

    // shift form
    set_id(1, 32'h99, 0, 0, 4, 1, 3, 4, 4'h8, 0, 1, 1, 1, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    load_edge();
    set_fwd(0, 0, 0, 1, 3, 32'h1);
    #1;
    total++;
    if (bus.alu_a !== 32'h1 || bus.alu_b !== 32'h4)
      $display("FAIL shift_direct: got a=%h b=%h, want a=00000001 b=00000004",
               bus.alu_a, bus.alu_b);
    else
      passed++;
    expect_out("shift_sel", 32'h1, 32'h4, 4'h8, 32'h1, 4, 1, 1, 0, 0, 0);

    // load-use hazard
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h1000, 0, 32'h8, 0, 2, 7, 0, 4'h2, 1, 0, 0, 1, 1, 0);
    load_edge();
    bus.stall = 1'b1;
    bus.id_rs = 7; bus.id_rt = 1;
    expect_out("hazard_rs", 32'h1000, 32'h8, 4'h2, 0, 7, 1, 1, 1, 0, 1);
    bus.id_rs = 1; bus.id_rt = 7;
    expect_out("hazard_rt", 32'h1000, 32'h8, 4'h2, 0, 7, 1, 1, 1, 0, 1);
    bus.id_rs = 8; bus.id_rt = 8;
    expect_out("hazard_nomatch", 32'h1000, 32'h8, 4'h2, 0, 7, 1, 1, 1, 0, 0);
    bus.stall = 1'b0;
    set_id(1, 32'h1000, 0, 32'h8, 0, 2, 0, 0, 4'h2, 1, 0, 0, 1, 1, 0);
    load_edge();
    bus.stall = 1'b1;
    bus.id_rs = 0; bus.id_rt = 0;
    expect_out("hazard_dest_r0", 32'h1000, 32'h8, 4'h2, 0, 0, 1, 1, 1, 0, 0);
    bus.stall = 1'b0;
    set_id(0, 32'h2000, 32'h3, 32'h4, 0, 3, 7, 0, 4'h2, 1, 0, 0, 1, 1, 0);
    load_edge();
    bus.stall = 1'b1;
    bus.id_rs = 7;
    expect_out("invalid_gated", 32'h2000, 32'h4, 4'h2, 32'h3, 7, 0, 0, 0, 0, 0);
    bus.stall = 1'b0;

    // stall holds, stall+flush gives a bubble
    set_id(1, 32'hA1, 32'hA2, 0, 0, 10, 11, 12, 4'h1, 0, 0, 1, 1, 0, 1);
    load_edge();
    expect_out("load_A", 32'hA1, 32'hA2, 4'h1, 32'hA2, 12, 1, 1, 0, 1, 0);
    bus.stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      set_id(1, 32'hB0 + i, 32'hC0 + i, 32'h5, 0, 13, 14, 15, 4'h7, 1, 0, 0, 0, 0, 0);
      load_edge();
      expect_out("stall_hold", 32'hA1, 32'hA2, 4'h1, 32'hA2, 12, 1, 1, 0, 1, 0);
    end
    bus.flush = 1'b1;
    load_edge();
    expect_out("stall_flush_bubble", 0, 0, 4'h2, 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    load_edge();
    expect_out("load_B", 32'hB2, 32'h5, 4'h7, 32'hC2, 14, 1, 0, 0, 0, 0);

    // async reset between edges
    set_id(1, 32'h12, 32'h34, 0, 0, 1, 2, 3, 4'h5, 0, 0, 1, 1, 1, 1);
    load_edge();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bus.alu_control !== 4'h2 || bus.ex_valid !== 1'b0 || bus.ex_write_reg !== 5'd0)
      $display("FAIL async_reset_direct: got ctrl=%h v=%b wr=%0d, want ctrl=2 v=0 wr=0",
               bus.alu_control, bus.ex_valid, bus.ex_write_reg);
    else
      passed++;
    expect_out("async_reset", 0, 0, 4'h2, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
